// File: rtl/fetch_stage_ctrl.sv
// Fetch-stage control: PC register, IF/ID pipeline register, bubble request and a stall watchdog.
// Optional stall/flush statistics counters are enabled by defining FETCH_STALL_STATS_EN.
module fetch_stage_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        Stall,
   input  logic        PCWrite,
   input  logic        IF_IDWrite,
   input  logic        Flush,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] Instr_in,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_PC4,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_Valid,
   output logic        Bubble,
   output logic        StallTimeout
`ifdef FETCH_STALL_STATS_EN
   ,
   output logic [15:0] StallCycles,
   output logic [15:0] FlushCount
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      HOLD     = 2'd1,
      REDIRECT = 2'd2
   } state_e;

   localparam logic [31:0] NOP       = 32'h0000_0000;
   localparam logic [3:0]  HOLD_TRIP = 4'hF;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] if_id_pc4_q, if_id_pc4_d;
   logic [31:0] if_id_instr_q, if_id_instr_d;
   logic        if_id_valid_q, if_id_valid_d;
   logic        bubble_q, bubble_d;
   logic        timeout_q, timeout_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic [31:0] pc_plus4;

   // Wraps naturally at 2^32.
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin : fsm_next
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (Flush)      state_d = REDIRECT;
            else if (Stall) state_d = HOLD;
         end
         HOLD: begin
            if (Flush)       state_d = REDIRECT;
            else if (!Stall) state_d = RUN;
         end
         REDIRECT: begin
            if (Flush)      state_d = REDIRECT;
            else if (Stall) state_d = HOLD;
            else            state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_comb begin : datapath_next
      pc_d          = pc_q;
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;

      // A resolved redirect wins over any stall request.
      if (Flush) begin
         pc_d          = BranchTarget;
         if_id_instr_d = NOP;
         if_id_valid_d = 1'b0;
      end else begin
         if (PCWrite) pc_d = pc_plus4;
         if (IF_IDWrite) begin
            if_id_instr_d = Instr_in;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
         end
      end

      bubble_d = Stall | Flush;
   end

   always_comb begin : watchdog_next
      hold_cnt_d = 4'd0;
      if (state_q == HOLD) begin
         hold_cnt_d = (hold_cnt_q == HOLD_TRIP) ? hold_cnt_q : hold_cnt_q + 4'd1;
      end
      timeout_d = timeout_q | (hold_cnt_d == HOLD_TRIP);
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q       <= RUN;
         pc_q          <= 32'h0;
         if_id_pc4_q   <= 32'h0;
         if_id_instr_q <= NOP;
         if_id_valid_q <= 1'b0;
         bubble_q      <= 1'b1;
         timeout_q     <= 1'b0;
         hold_cnt_q    <= 4'd0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc4_q   <= if_id_pc4_d;
         if_id_instr_q <= if_id_instr_d;
         if_id_valid_q <= if_id_valid_d;
         bubble_q      <= bubble_d;
         timeout_q     <= timeout_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign PC           = pc_q;
   assign IF_ID_PC4    = if_id_pc4_q;
   assign IF_ID_Instr  = if_id_instr_q;
   assign IF_ID_Valid  = if_id_valid_q;
   assign Bubble       = bubble_q;
   assign StallTimeout = timeout_q;

`ifdef FETCH_STALL_STATS_EN
   logic [15:0] stall_cycles_q, stall_cycles_d;
   logic [15:0] flush_count_q, flush_count_d;

   always_comb begin : stats_next
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if ((state_q == HOLD) && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
      if (Flush && (flush_count_q != 16'hFFFF))              flush_count_d  = flush_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_q <= 16'd0;
         flush_count_q  <= 16'd0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign StallCycles = stall_cycles_q;
   assign FlushCount  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Self-checking bench for fetch_stage_ctrl: vector table plus hand-written stall/watchdog/reset sequences.
module tb_fetch_stage_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic        bubble;
      logic        timeout;
   } exp_t;

   typedef struct packed {
      logic        stall;
      logic        pcw;
      logic        ifw;
      logic        flush;
      logic [31:0] target;
      logic [31:0] instr;
      exp_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, pc_write, ifid_write, flush;
   logic [31:0] branch_target, instr_in;
   logic [31:0] pc, ifid_pc4, ifid_instr;
   logic        ifid_valid, bubble, stall_timeout;
`ifdef FETCH_STALL_STATS_EN
   logic [15:0] stall_cycles, flush_count;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   vec_t vecs[13];

   always #5 clk = ~clk;

   fetch_stage_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .Stall        (stall),
      .PCWrite      (pc_write),
      .IF_IDWrite   (ifid_write),
      .Flush        (flush),
      .BranchTarget (branch_target),
      .Instr_in     (instr_in),
      .PC           (pc),
      .IF_ID_PC4    (ifid_pc4),
      .IF_ID_Instr  (ifid_instr),
      .IF_ID_Valid  (ifid_valid),
      .Bubble       (bubble),
      .StallTimeout (stall_timeout)
`ifdef FETCH_STALL_STATS_EN
      ,
      .StallCycles  (stall_cycles),
      .FlushCount   (flush_count)
`endif
   );

   function automatic exp_t ex(input logic [31:0] p, input logic [31:0] p4, input logic [31:0] ins,
                               input logic v, input logic b, input logic t);
      ex = '{pc: p, pc4: p4, instr: ins, valid: v, bubble: b, timeout: t};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic compare_out(input string tag, input exp_t e);
      check({tag, ".pc"},      pc,                     e.pc);
      check({tag, ".pc4"},     ifid_pc4,               e.pc4);
      check({tag, ".instr"},   ifid_instr,             e.instr);
      check({tag, ".valid"},   {31'd0, ifid_valid},    {31'd0, e.valid});
      check({tag, ".bubble"},  {31'd0, bubble},        {31'd0, e.bubble});
      check({tag, ".timeout"}, {31'd0, stall_timeout}, {31'd0, e.timeout});
   endtask

   // Drive one cycle of stimulus, queue its expectation, and score it after the edge.
   task automatic step(input logic st, input logic pcw, input logic ifw, input logic fl,
                       input logic [31:0] tgt, input logic [31:0] ins, input exp_t e, input string tag);
      exp_t got;
      @(negedge clk);
      stall = st; pc_write = pcw; ifid_write = ifw; flush = fl;
      branch_target = tgt; instr_in = ins;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         errors++;
         $display("FAIL %s.scoreboard: queue empty", tag);
      end else begin
         got = sb_q.pop_front();
         compare_out(tag, got);
      end
   endtask

   initial begin
      //               st   pcw  ifw  fl   target        instr          pc            pc4           instr         v  b  t
      vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h8C010004, ex(32'h4,        32'h4,        32'h8C010004, 1, 0, 0)};
      vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h8C010004, ex(32'h8,        32'h8,        32'h8C010004, 1, 0, 0)};
      vecs[2]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h11111111, ex(32'hC,        32'hC,        32'h11111111, 1, 0, 0)};
      vecs[3]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h22222222, ex(32'h10,       32'h10,       32'h22222222, 1, 0, 0)};
      vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h33333333, ex(32'h10,       32'h10,       32'h22222222, 1, 1, 0)};
      vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,        32'h33333333, ex(32'h10,       32'h10,       32'h22222222, 1, 1, 0)};
      vecs[6]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h44444444, ex(32'h14,       32'h14,       32'h44444444, 1, 0, 0)};
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,        32'h55555555, ex(32'h18,       32'h14,       32'h44444444, 1, 0, 0)};
      vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,32'h40,       32'h66666666, ex(32'h40,       32'h14,       32'h0,        0, 1, 0)};
      vecs[9]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h77777777, ex(32'h44,       32'h44,       32'h77777777, 1, 0, 0)};
      vecs[10] = '{1'b0,1'b1,1'b1,1'b1,32'hFFFFFFFC, 32'h88888888, ex(32'hFFFFFFFC, 32'h44,       32'h0,        0, 1, 0)};
      vecs[11] = '{1'b0,1'b1,1'b1,1'b0,32'h0,        32'h99999999, ex(32'h0,        32'h0,        32'h99999999, 1, 0, 0)};
      vecs[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,        32'hAAAAAAAA, ex(32'h0,        32'h0,        32'h99999999, 1, 0, 0)};

      rst = 1'b1;
      stall = 1'b0; pc_write = 1'b0; ifid_write = 1'b0; flush = 1'b0;
      branch_target = 32'h0; instr_in = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      compare_out("reset", ex(32'h0, 32'h0, 32'h0, 0, 1, 0));
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].stall, vecs[i].pcw, vecs[i].ifw, vecs[i].flush,
              vecs[i].target, vecs[i].instr, vecs[i].exp, $sformatf("vec%0d", i));
      end
`ifdef FETCH_STALL_STATS_EN
      check("stats.stall_cycles", {16'd0, stall_cycles}, 32'd2);
      check("stats.flush_count",  {16'd0, flush_count},  32'd2);
`endif

      // Two 10-cycle stalls separated by a free cycle: the watchdog counter must restart.
      for (int r = 0; r < 2; r++) begin
         for (int n = 0; n < 10; n++)
            step(1, 0, 0, 0, 32'h0, 32'h0, ex(32'h0, 32'h0, 32'h99999999, 1, 1, 0), $sformatf("short%0d_%0d", r, n));
         step(0, 0, 0, 0, 32'h0, 32'h0, ex(32'h0, 32'h0, 32'h99999999, 1, 0, 0), $sformatf("short%0d_rel", r));
      end

      // Stall held 15 cycles: watchdog trips at the end of the 15th HOLD cycle and sticks.
      for (int n = 1; n <= 15; n++)
         step(1, 0, 0, 0, 32'h0, 32'h0, ex(32'h0, 32'h0, 32'h99999999, 1, 1, 0), $sformatf("wd%0d", n));
      step(0, 0, 0, 0, 32'h0,   32'h0,        ex(32'h0,   32'h0,   32'h99999999, 1, 0, 1), "wd_trip");
      step(0, 0, 0, 0, 32'h0,   32'h0,        ex(32'h0,   32'h0,   32'h99999999, 1, 0, 1), "wd_sticky");
      step(0, 0, 0, 1, 32'h100, 32'h0,        ex(32'h100, 32'h0,   32'h0,        0, 1, 1), "wd_flush");
      step(0, 1, 1, 0, 32'h0,   32'hBBBBBBBB, ex(32'h104, 32'h104, 32'hBBBBBBBB, 1, 0, 1), "wd_run");
      step(1, 0, 0, 0, 32'h0,   32'h0,        ex(32'h104, 32'h104, 32'hBBBBBBBB, 1, 1, 1), "hold0");
      step(1, 0, 0, 0, 32'h0,   32'h0,        ex(32'h104, 32'h104, 32'hBBBBBBBB, 1, 1, 1), "hold1");

      // Asynchronous reset between edges while in HOLD, with Stall still asserted.
      #2;
      rst = 1'b1;
      #1;
      compare_out("async_rst", ex(32'h0, 32'h0, 32'h0, 0, 1, 0));
`ifdef FETCH_STALL_STATS_EN
      check("async_rst.stall_cycles", {16'd0, stall_cycles}, 32'd0);
      check("async_rst.flush_count",  {16'd0, flush_count},  32'd0);
`endif
      rst = 1'b0;
      step(0, 1, 1, 0, 32'h0, 32'hCCCCCCCC, ex(32'h4, 32'h4, 32'hCCCCCCCC, 1, 0, 0), "post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Stall, input, 1, hazard stall request; insert bubble into ID/EX.
REQ-004 SHALL have port PCWrite, input, 1, PC update enable.
REQ-005 SHALL have port IF_IDWrite, input, 1, IF/ID register update enable.
REQ-006 SHALL have port Flush, input, 1, branch taken or jump resolved in ID; squash IF/ID.
REQ-007 SHALL have port BranchTarget, input, 32, redirect address, used when Flush=1.
REQ-008 SHALL have port Instr_in, input, 32, instruction fetched at PC.
REQ-009 SHALL have port PC, output, 32, current fetch address.
REQ-010 SHALL have port IF_ID_PC4, output, 32, registered PC+4 of the instruction in ID.
REQ-011 SHALL have port IF_ID_Instr, output, 32, registered instruction in ID.
REQ-012 SHALL have port IF_ID_Valid, output, 1, IF/ID holds a real instruction.
REQ-013 SHALL have port Bubble, output, 1, registered; ID/EX control bundle forced to zero this cycle.
REQ-014 SHALL have port StallTimeout, output, 1, sticky; consecutive-stall watchdog tripped.

Function
REQ-015 SHALL update PC to BranchTarget when Flush=1, regardless of PCWrite; Flush has priority over the stall.
REQ-016 SHALL otherwise update PC to PC+4 when PCWrite=1, and hold PC when PCWrite=0; addition wraps mod 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-017 SHALL, when Flush=1, load IF_ID_Instr=0x00000000 (NOP) and IF_ID_Valid=0 on the next edge; IF_ID_PC4 holds.
REQ-018 SHALL otherwise, when IF_IDWrite=1, load IF_ID_Instr=Instr_in, IF_ID_PC4=PC+4, and IF_ID_Valid=1; when IF_IDWrite=0, hold all IF/ID fields.
REQ-019 SHALL register Bubble=Stall|Flush, one cycle latency after the request edge.
REQ-020 SHALL use state machine states RUN, HOLD, and REDIRECT: RUN->HOLD on Stall & !Flush; any->REDIRECT on Flush; HOLD->RUN on !Stall; REDIRECT->RUN next cycle unless Flush or Stall (then REDIRECT or HOLD).
REQ-021 SHALL count consecutive HOLD cycles in a 4-bit saturating counter, cleared on any non-HOLD cycle.
REQ-022 SHALL set StallTimeout when the counter reaches 15; it stays set until reset.
REQ-023 SHALL treat PCWrite=1 with IF_IDWrite=0 as legal: PC advances while IF/ID holds.

Reset
REQ-024 SHALL, on rst=1, asynchronously set PC=0x00000000, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0, Bubble=1, StallTimeout=0, state=RUN, and counters=0.
REQ-025 SHALL override all inputs with reset asserted mid-stall or mid-flush; the first edge after deassertion behaves as RUN.

Configuration
REQ-026 SHALL, when macro FETCH_STALL_STATS_EN is defined, add outputs StallCycles[15:0] and FlushCount[15:0], each incremented per HOLD cycle or per Flush cycle, saturating at 0xFFFF, and reset to 0.
REQ-027 SHALL, when FETCH_STALL_STATS_EN is undefined, omit those ports and counters; all other behaviour is identical.

Verification
REQ-028 SHALL cover release from reset with PCWrite=IF_IDWrite=1, Instr_in=0x8C010004 -> after 2 edges PC=0x8, IF_ID_Instr=0x8C010004, IF_ID_PC4=0x8, IF_ID_Valid=1.
REQ-029 SHALL cover Stall=1, PCWrite=0, IF_IDWrite=0 for 2 cycles at PC=0x10 -> PC stays 0x10, IF/ID unchanged, Bubble=1 for 2 cycles, state HOLD, then RUN.
REQ-030 SHALL cover Flush=1 with BranchTarget=0x40 while Stall=1 -> next PC=0x40, IF_ID_Instr=0, IF_ID_Valid=0, Bubble=1.
REQ-031 SHALL cover PC=0xFFFFFFFC with PCWrite=1 -> PC=0x00000000.
REQ-032 SHALL cover Stall held 15 cycles -> StallTimeout=1 after the 15th HOLD cycle and remaining 1 after Stall drops, until rst.
REQ-033 SHALL cover rst pulsed mid-HOLD (asynchronous, between edges) -> outputs take reset values immediately and StallCycles=0 with FETCH_STALL_STATS_EN defined.
